// File: rtl/nn_layer_sequencer_if.sv
// ----------------------------------------------------------------------------
// nn_layer_sequencer_if
// Bundles the sample-source handshake and the layer control lines of the
// neuron network sequencer.
//
//   in_valid  : request for a new inference (source -> sequencer)
//   in_ready  : sequencer idle and able to accept a request
//   hold      : freeze request, pauses the whole network
//   load_o    : one-cycle strobe that latches the input features
//   en_o      : shared neuron enable (= !hold)
//   run_o     : one-hot Run pulse, bit i drives layer i
//   layer_o   : index of the layer launched or being waited on
//   busy      : inference in progress
//   out_valid : one-cycle pulse, final layer outputs are stable
//
// Modports: master = sequencer side, slave = source/network side.
// ----------------------------------------------------------------------------
interface nn_layer_sequencer_if #(
    parameter int NUM_LAYERS = 2
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  hold;
    logic                  load_o;
    logic                  en_o;
    logic [NUM_LAYERS-1:0] run_o;
    logic [2:0]            layer_o;
    logic                  busy;
    logic                  out_valid;

    modport master (
        input  in_valid, hold,
        output in_ready, load_o, en_o, run_o, layer_o, busy, out_valid
    );

    modport slave (
        output in_valid, hold,
        input  in_ready, load_o, en_o, run_o, layer_o, busy, out_valid
    );
endinterface

// File: rtl/nn_layer_sequencer.sv
// ----------------------------------------------------------------------------
// nn_layer_sequencer
// Sequences a multi-layer fixed-point neuron network one layer at a time:
// accepts a request (pulsing load_o), fires a one-cycle Run to each layer in
// turn spaced NEURON_LATENCY+1 cycles apart, then pulses out_valid.
//
// Ports:
//   clk         : clock, rising edge
//   rst         : asynchronous active-high reset
//   bus         : nn_layer_sequencer_if.master (handshake + layer control)
//   infer_count : (optional) completed inferences, wraps at 16 bits
//   cycle_last  : (optional) acceptance-to-out_valid cycles of the most
//                 recent inference, saturating at 0xFFFF
//
// Parameters: NUM_LAYERS (1..8), NEURON_LATENCY (>= 2).
// Optional feature macro: NN_SEQ_INFER_COUNT_EN adds infer_count/cycle_last.
// ----------------------------------------------------------------------------
module nn_layer_sequencer #(
    parameter int NUM_LAYERS     = 2,
    parameter int NEURON_LATENCY = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    nn_layer_sequencer_if.master bus
`ifdef NN_SEQ_INFER_COUNT_EN
    ,
    output logic [15:0]          infer_count,
    output logic [15:0]          cycle_last
`endif
);

    localparam int              CNT_W      = $clog2(NEURON_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(NEURON_LATENCY - 1);
    localparam logic [2:0]       LAYER_LAST = 3'(NUM_LAYERS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       layer_q, layer_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             accept;

    // Outputs are decodes of registered state; hold masks the pulses so a
    // frozen LAUNCH/DONE replays its pulse in the first non-held cycle.
    assign bus.in_ready  = (state_q == S_IDLE) && !bus.hold;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.load_o    = accept;
    assign bus.en_o      = !bus.hold;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.layer_o   = layer_q;
    assign bus.out_valid = (state_q == S_DONE) && !bus.hold;
    assign bus.run_o     = (state_q == S_LAUNCH && !bus.hold)
                           ? (NUM_LAYERS'(1) << layer_q) : '0;

    always_comb begin
        // NOTE: every next-state signal gets a default hold value first, so no
        // path through the case leaves one unassigned (no inferred latch).
        state_d = state_q;
        layer_d = layer_q;
        cnt_d   = cnt_q;
        if (!bus.hold) begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        layer_d = 3'd0;
                        state_d = S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_q == CNT_LAST) begin
                        if (layer_q == LAYER_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            layer_d = layer_q + 3'd1;
                            state_d = S_LAUNCH;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            layer_q <= 3'd0;
            cnt_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q <= state_d;
            layer_q <= layer_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef NN_SEQ_INFER_COUNT_EN
    logic [15:0] infer_q;
    logic [15:0] last_q;
    logic [15:0] elapsed_q;

    // elapsed_q reads 1 in the cycle after acceptance, so in the out_valid
    // cycle it equals the acceptance-to-out_valid distance (held cycles too).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            infer_q   <= 16'd0;
            last_q    <= 16'd0;
            elapsed_q <= 16'd0;
        end else begin
            if (accept) begin
                elapsed_q <= 16'd1;
            end else if (state_q != S_IDLE && elapsed_q != 16'hFFFF) begin
                elapsed_q <= elapsed_q + 16'd1;
            end
            if (bus.out_valid) begin
                infer_q <= infer_q + 16'd1;
                last_q  <= elapsed_q;
            end
        end
    end

    assign infer_count = infer_q;
    assign cycle_last  = last_q;
`endif

endmodule
